uart_cmd_wrapper: RTL and testbench
===================================

UART_CMD_WRAPPER -- requirements
Module: uart_cmd_wrapper

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, clocks per bit (19200 baud at 50 MHz); legal range 16..8191.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port RX  input  1  serial line from remote; idle high; asynchronous to clk.
REQ-005 SHALL have port TX  output  1  serial line to remote; idle high.
REQ-006 SHALL have port cmd  output  16  last complete command; high byte first on the wire.
REQ-007 SHALL have port cmd_rdy  output  1  level; a new cmd is valid.
REQ-008 SHALL have port clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
REQ-009 SHALL have port resp  input  8  response byte to transmit.
REQ-010 SHALL have port trmt  input  1  one-cycle pulse; start transmitting resp.
REQ-011 SHALL have port tx_done  output  1  level; last response fully sent.

Function
REQ-012 SHALL pass RX through a two-flop synchronizer; all receive decisions use the second flop (rx_s).
REQ-013 Receiver states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE: when rx_s==0, go to START and load baud counter with BAUD_DIV/2 (integer divide).
REQ-015 Baud counter SHALL count down; a sample occurs on the cycle it reads 0, after which it reloads BAUD_DIV-1.
REQ-016 START sample: rx_s==0 -> DATA; rx_s==1 -> false start, return to IDLE, nothing reported.
REQ-017 DATA: 8 samples, LSB first, shifted into an 8-bit register; after the 8th -> STOP.
REQ-018 STOP sample: rx_s==1 -> byte valid (1-cycle internal strobe); rx_s==0 -> framing error, byte discarded; either case -> IDLE.
REQ-019 Byte assembler states SHALL be HIGH, LOW; reset state HIGH.
REQ-020 HIGH + valid byte: store byte as cmd high byte, go LOW, clear cmd_rdy.
REQ-021 LOW + valid byte: cmd <= {high, byte} in one update, set cmd_rdy, go HIGH.
REQ-022 Framing error in either assembler state SHALL return assembler to HIGH and discard any stored high byte; cmd and cmd_rdy unchanged.
REQ-023 cmd_rdy SHALL rise on the cycle after the clock edge that samples the second byte's stop bit.
REQ-024 clr_cmd_rdy SHALL clear cmd_rdy next cycle; simultaneous set (REQ-021) and clr_cmd_rdy -> set wins.
REQ-025 cmd SHALL change only at REQ-021; stable at all other times.
REQ-026 Transmitter states SHALL be IDLE, XMIT; frame = start bit 0, 8 data bits LSB first, stop bit 1; each bit exactly BAUD_DIV clocks.
REQ-027 trmt in IDLE: latch resp, clear tx_done, drive TX=0 from the next cycle, go XMIT.
REQ-028 trmt while in XMIT SHALL be ignored; resp changes during XMIT SHALL not affect the frame.
REQ-029 After the full stop-bit period: set tx_done, return to IDLE with TX=1; tx_done holds until next accepted trmt.
REQ-030 Total TX frame SHALL be 10*BAUD_DIV clocks from first TX=0 cycle to tx_done rising.
REQ-031 Receiver and transmitter SHALL operate fully independently (full duplex).

Reset
REQ-032 While rst high: TX=1, cmd=16'h0000, cmd_rdy=0, tx_done=0, synchronizer flops=1, receiver IDLE, assembler HIGH, transmitter IDLE, baud counters 0.
REQ-033 Reset asserted mid-frame (either direction) SHALL abort the frame with no partial byte retained; TX returns to 1 on the cycle after the reset edge.

Verification
REQ-034 Remote sends 0x40 then 0x04 at BAUD_DIV -> cmd=16'h4004, cmd_rdy=1 one cycle after second stop sample; clr_cmd_rdy pulse -> cmd_rdy=0 next cycle, cmd still 16'h4004.
REQ-035 trmt with resp=8'hA5 -> TX bit sequence 0,1,0,1,0,0,1,0,1,1 each BAUD_DIV clocks; tx_done=1 exactly 10*BAUD_DIV clocks after first low; remote decodes 0xA5; trmt pulsed mid-frame ignored.
REQ-036 First byte 0x2A sent with stop bit forced 0, then 0x40,0x04 -> cmd=16'h4004 (0x2A discarded, no cmd_rdy after first pair).
REQ-037 RX glitch low for BAUD_DIV/4 clocks -> false start; no byte, assembler stays HIGH; subsequent 0x60,0x00 -> cmd=16'h6000.
REQ-038 clr_cmd_rdy asserted on the exact cycle cmd_rdy would set -> cmd_rdy=1; rst asserted after 4 RX data bits of a high byte -> cmd=0, cmd_rdy=0, next two bytes 0x12,0x34 -> cmd=16'h1234.
REQ-039 Full-duplex: 0xA5 transmitted while 0x20,0x02 received simultaneously -> both complete correctly, cmd=16'h2002.

Source files
------------

// File: rtl/uart_cmd_wrapper.sv
// UART command wrapper: receives two-byte commands (high byte first) from a
// remote host and transmits single response bytes, full duplex, 8N1 framing.
module uart_cmd_wrapper #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  // 13 bits covers the largest legal divider (8191).
  localparam int            CW      = 13;
  localparam logic [CW-1:0] LP_HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] LP_FULL = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic       {ASM_HIGH, ASM_LOW}                   asm_state_t;
  typedef enum logic       {TX_IDLE, TX_XMIT}                    tx_state_t;

  // ---------------------------------------------------------------------------
  // RX synchronizer
  // ---------------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rx_s;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_s    <= r_rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  rx_state_t     r_rx_state, w_rx_state_nxt;
  logic [CW-1:0] r_rx_cnt,   w_rx_cnt_nxt;
  logic [2:0]    r_rx_bits,  w_rx_bits_nxt;
  logic [7:0]    r_rx_shift, w_rx_shift_nxt;
  logic          w_rx_tick;
  logic          w_byte_vld;
  logic          w_frm_err;

  // Receiver state and sampling registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bits  <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bits  <= w_rx_bits_nxt;
      r_rx_shift <= w_rx_shift_nxt;
    end
  end

  // Receiver next state: half-bit delay to mid start bit, then one sample
  // per bit period when the down-counter reads zero.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bits_nxt  = r_rx_bits;
    w_rx_shift_nxt = r_rx_shift;
    w_byte_vld     = 1'b0;
    w_frm_err      = 1'b0;
    w_rx_tick      = (r_rx_cnt == '0);
    case (r_rx_state)
      RX_IDLE: begin
        if (!r_rx_s) begin
          w_rx_state_nxt = RX_START;
          w_rx_cnt_nxt   = LP_HALF;
        end
      end
      RX_START: begin
        if (w_rx_tick) begin
          w_rx_cnt_nxt = LP_FULL;
          if (!r_rx_s) begin
            w_rx_state_nxt = RX_DATA;
            w_rx_bits_nxt  = '0;
          end else begin
            w_rx_state_nxt = RX_IDLE;   // glitch, not a real start bit
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt - 1'b1;
        end
      end
      RX_DATA: begin
        if (w_rx_tick) begin
          w_rx_cnt_nxt   = LP_FULL;
          w_rx_shift_nxt = {r_rx_s, r_rx_shift[7:1]};
          if (r_rx_bits == 3'd7) w_rx_state_nxt = RX_STOP;
          else                   w_rx_bits_nxt  = r_rx_bits + 1'b1;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt - 1'b1;
        end
      end
      RX_STOP: begin
        if (w_rx_tick) begin
          w_rx_cnt_nxt   = LP_FULL;
          w_rx_state_nxt = RX_IDLE;
          if (r_rx_s) w_byte_vld = 1'b1;
          else        w_frm_err  = 1'b1;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt - 1'b1;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command byte assembler
  // ---------------------------------------------------------------------------
  asm_state_t r_asm_state, w_asm_state_nxt;
  logic [7:0] r_hi_byte,   w_hi_byte_nxt;
  logic [15:0] r_cmd,      w_cmd_nxt;
  logic       r_cmd_rdy,   w_cmd_rdy_nxt;

  // Assembler state, stored high byte and command outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_asm_state <= ASM_HIGH;
      r_hi_byte   <= '0;
      r_cmd       <= '0;
      r_cmd_rdy   <= 1'b0;
    end else begin
      r_asm_state <= w_asm_state_nxt;
      r_hi_byte   <= w_hi_byte_nxt;
      r_cmd       <= w_cmd_nxt;
      r_cmd_rdy   <= w_cmd_rdy_nxt;
    end
  end

  // Pair bytes into a command; the set of cmd_rdy is applied after the
  // acknowledge so a coincident set takes priority.
  always_comb begin
    w_asm_state_nxt = r_asm_state;
    w_hi_byte_nxt   = r_hi_byte;
    w_cmd_nxt       = r_cmd;
    w_cmd_rdy_nxt   = r_cmd_rdy;
    if (clr_cmd_rdy) w_cmd_rdy_nxt = 1'b0;
    if (w_byte_vld) begin
      case (r_asm_state)
        ASM_HIGH: begin
          w_hi_byte_nxt   = r_rx_shift;
          w_asm_state_nxt = ASM_LOW;
          w_cmd_rdy_nxt   = 1'b0;
        end
        ASM_LOW: begin
          w_cmd_nxt       = {r_hi_byte, r_rx_shift};
          w_cmd_rdy_nxt   = 1'b1;
          w_asm_state_nxt = ASM_HIGH;
        end
        default: w_asm_state_nxt = ASM_HIGH;
      endcase
    end else if (w_frm_err) begin
      // Resynchronize on a bad frame: the pending high byte is dropped.
      w_asm_state_nxt = ASM_HIGH;
      w_hi_byte_nxt   = '0;
    end
  end

  assign cmd     = r_cmd;
  assign cmd_rdy = r_cmd_rdy;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_t     r_tx_state, w_tx_state_nxt;
  logic [CW-1:0] r_tx_cnt,   w_tx_cnt_nxt;
  logic [3:0]    r_tx_bits,  w_tx_bits_nxt;
  logic [9:0]    r_tx_shift, w_tx_shift_nxt;
  logic          r_tx_done,  w_tx_done_nxt;
  logic          r_tx,       w_tx_nxt;

  // Transmitter state, frame shifter and registered line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bits  <= '0;
      r_tx_shift <= '1;
      r_tx_done  <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bits  <= w_tx_bits_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_done  <= w_tx_done_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  // Transmitter next state: whole 10-bit frame is latched on trmt, so resp
  // may change freely while the frame is on the wire.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bits_nxt  = r_tx_bits;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_done_nxt  = r_tx_done;
    case (r_tx_state)
      TX_IDLE: begin
        if (trmt) begin
          w_tx_state_nxt = TX_XMIT;
          w_tx_shift_nxt = {1'b1, resp, 1'b0};
          w_tx_cnt_nxt   = LP_FULL;
          w_tx_bits_nxt  = '0;
          w_tx_done_nxt  = 1'b0;
        end
      end
      TX_XMIT: begin
        if (r_tx_cnt == '0) begin
          if (r_tx_bits == 4'd9) begin
            w_tx_state_nxt = TX_IDLE;
            w_tx_cnt_nxt   = '0;
            w_tx_done_nxt  = 1'b1;
          end else begin
            w_tx_shift_nxt = {1'b1, r_tx_shift[9:1]};
            w_tx_bits_nxt  = r_tx_bits + 1'b1;
            w_tx_cnt_nxt   = LP_FULL;
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt - 1'b1;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
    w_tx_nxt = (w_tx_state_nxt == TX_XMIT) ? w_tx_shift_nxt[0] : 1'b1;
  end

  assign TX      = r_tx;
  assign tx_done = r_tx_done;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Scoreboard bench for uart_cmd_wrapper: a remote-host line driver feeds RX,
// a remote receiver decodes TX, expected results are queued at stimulus time.
module tb_uart_cmd_wrapper;
  localparam int B = 16;
  localparam int H = B / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        trmt = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX, cmd_rdy, tx_done;
  logic [15:0] cmd;

  int checks = 0, failures = 0, cyc = 0;
  int tx_sent = 0, tx_seen = 0;

  typedef struct {logic [15:0] cmd; int cyc;} rx_exp_t;
  rx_exp_t    rxq[$];
  logic [7:0] txq[$];

  uart_cmd_wrapper #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .trmt(trmt), .tx_done(tx_done)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bit period on RX; optionally pulse clr_cmd_rdy so the DUT samples it
  // on the same edge that samples this bit (stop-bit sample point).
  task automatic line(input logic v, input bit hit);
    RX = v;
    for (int k = 0; k < B; k++) begin
      clr_cmd_rdy = hit && (k == H + 3);
      @(posedge clk); #1;
    end
    clr_cmd_rdy = 1'b0;
  endtask

  // Stop bit is sampled 4+H+9B edges after the edge preceding the start bit.
  task automatic send_byte(input logic [7:0] b, input logic stop, input bit push,
                           input logic [15:0] exp, input bit hit);
    int t0;
    @(posedge clk); #1;
    t0 = cyc;
    if (push) rxq.push_back('{exp, t0 + 4 + H + 9 * B});
    line(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) line(b[i], 1'b0);
    line(stop, hit);
    RX = 1'b1;
  endtask

  task automatic send_pair(input logic [7:0] hi, input logic [7:0] lo, input bit hit);
    send_byte(hi, 1'b1, 1'b0, 16'h0, 1'b0);
    send_byte(lo, 1'b1, 1'b1, {hi, lo}, hit);
  endtask

  task automatic clr_pulse(input logic [15:0] exp_cmd);
    @(posedge clk); #1 clr_cmd_rdy = 1'b1;
    @(posedge clk); #1 clr_cmd_rdy = 1'b0;
    chk("clr_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("clr_cmd_hold", {16'd0, cmd}, {16'd0, exp_cmd});
  endtask

  task automatic send_tx(input logic [7:0] b);
    @(posedge clk); #1;
    resp = b; trmt = 1'b1;
    txq.push_back(b);
    tx_sent++;
    @(posedge clk); #1 trmt = 1'b0;
  endtask

  task automatic wait_tx();
    for (int i = 0; i < 30 * B && tx_seen != tx_sent; i++) @(posedge clk);
    #1;
    chk("tx_frames", tx_seen, tx_sent);
  endtask

  // Command monitor: every cmd_rdy rise pops one expectation (value + cycle);
  // cmd may only move together with such a rise.
  logic        prev_rdy = 1'b0;
  logic [15:0] prev_cmd = 16'h0;
  rx_exp_t     re;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (cmd_rdy && !prev_rdy) begin
        if (rxq.size() == 0) chk("rdy_unexpected", 32'd1, 32'd0);
        else begin
          re = rxq.pop_front();
          chk("cmd", {16'd0, cmd}, {16'd0, re.cmd});
          chk("rdy_cycle", cyc, re.cyc);
        end
      end
      if (cmd != prev_cmd) chk("cmd_only_on_set", {31'd0, cmd_rdy && !prev_rdy}, 32'd1);
    end
    prev_rdy = cmd_rdy;
    prev_cmd = cmd;
  end

  // Remote receiver: samples mid-bit, checks frame, byte and tx_done timing.
  int         tc;
  logic [7:0] te, tg;
  logic [9:0] tf;
  initial forever begin
    @(negedge clk);
    if (!rst && TX === 1'b0) begin
      tc = cyc;
      chk("tx_done_clr", {31'd0, tx_done}, 32'd0);
      if (txq.size() == 0) begin chk("tx_unexpected", 32'd1, 32'd0); te = 8'h00; end
      else te = txq.pop_front();
      tf = {1'b1, te, 1'b0};
      for (int k = 0; k < 10; k++) begin
        while (cyc != tc + k * B + H) @(negedge clk);
        chk("tx_bit", {31'd0, TX}, {31'd0, tf[k]});
        if (k >= 1 && k <= 8) tg[k-1] = TX;
      end
      chk("tx_byte", {24'd0, tg}, {24'd0, te});
      while (cyc != tc + 10 * B - 1) @(negedge clk);
      chk("tx_done_early", {31'd0, tx_done}, 32'd0);
      @(negedge clk);
      chk("tx_done_rise", {31'd0, tx_done}, 32'd1);
      chk("tx_idle", {31'd0, TX}, 32'd1);
      tx_seen++;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    idle(3);
    chk("rst_tx", {31'd0, TX}, 32'd1);
    chk("rst_cmd", {16'd0, cmd}, 32'd0);
    chk("rst_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    rst = 1'b0;
    idle(2 * B);

    // Basic command plus acknowledge
    send_pair(8'h40, 8'h04, 1'b0);
    clr_pulse(16'h4004);

    // Response 0xA5 with an ignored mid-frame trmt and resp change
    send_tx(8'hA5);
    idle(3 * B);
    resp = 8'h3C; trmt = 1'b1;
    @(posedge clk); #1 trmt = 1'b0;
    wait_tx();
    idle(2 * B);
    chk("tx_done_hold", {31'd0, tx_done}, 32'd1);
    chk("tx_line_idle", {31'd0, TX}, 32'd1);

    // Framing error on a would-be high byte
    send_byte(8'h2A, 1'b0, 1'b0, 16'h0, 1'b0);
    idle(2 * B);
    send_pair(8'h40, 8'h04, 1'b0);
    clr_pulse(16'h4004);

    // Framing error while a high byte is pending drops that byte
    send_byte(8'h77, 1'b1, 1'b0, 16'h0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0, 16'h0, 1'b0);
    idle(2 * B);
    send_pair(8'h81, 8'h18, 1'b0);
    clr_pulse(16'h8118);

    // Short glitch is a false start
    @(posedge clk); #1 RX = 1'b0;
    idle(B / 4);
    RX = 1'b1;
    idle(2 * B);
    send_pair(8'h60, 8'h00, 1'b0);
    clr_pulse(16'h6000);

    // Acknowledge on the same edge as the set: set wins
    send_pair(8'h5A, 8'hC3, 1'b1);
    idle(2);
    chk("set_wins", {31'd0, cmd_rdy}, 32'd1);

    // Reset in the middle of a high byte
    @(posedge clk); #1;
    line(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) line(i[0], 1'b0);
    rst = 1'b1; RX = 1'b1;
    @(posedge clk); #1;
    chk("midrst_cmd", {16'd0, cmd}, 32'd0);
    chk("midrst_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("midrst_tx", {31'd0, TX}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    idle(2 * B);
    send_pair(8'h12, 8'h34, 1'b0);
    clr_pulse(16'h1234);

    // Full duplex
    fork
      send_pair(8'h20, 8'h02, 1'b0);
      send_tx(8'hA5);
    join
    wait_tx();
    clr_pulse(16'h2002);

    idle(2 * B);
    chk("rxq_left", rxq.size(), 32'd0);
    chk("txq_left", txq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
